// File: rtl/m_prog_loader.sv
// UART boot loader: receives a length-prefixed little-endian program image over 8N1 serial
// and writes it word-by-word into instruction memory, then releases the processor via w_done.
module m_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 12
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_rxd,
    output logic              w_we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [31:0]       w_wdata,
    output logic              w_done,
    output logic              w_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLd = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLd = CntW'(CLKS_PER_BIT - 1);
    localparam logic [16:0] MaxWords = 17'(2 ** ADDR_W);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_st_e;
    typedef enum logic [2:0] {LdLen0, LdLen1, LdData, LdDone, LdErr} ld_st_e;

    logic            rx_meta_q, rxs_q;
    rx_st_e          rx_st_q, rx_st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            rx_valid, rx_ferr;
    logic [7:0]      rx_byte;

    ld_st_e          ld_st_q, ld_st_d;
    logic [15:0]     len_q, len_d, len_new;
    logic [16:0]     wcnt_q, wcnt_d, wcnt_inc;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     word_q, word_d;
    logic            we_q, we_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // Byte receiver: sample points sit at mid-bit, counted from the detected start edge.
    always_comb begin
        rx_st_d  = rx_st_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        unique case (rx_st_q)
            RxIdle: begin
                if (!rxs_q) begin
                    rx_st_d = RxStart;
                    cnt_d   = HalfLd;
                end
            end
            RxStart: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs_q) begin
                    rx_st_d = RxIdle;
                end else begin
                    rx_st_d = RxData;
                    cnt_d   = FullLd;
                    bit_d   = 3'd0;
                end
            end
            RxData: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    cnt_d   = FullLd;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        rx_st_d = RxStop;
                    end
                end
            end
            RxStop: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rx_st_d  = RxIdle;
                    rx_valid = rxs_q;
                    rx_ferr  = !rxs_q;
                end
            end
            default: rx_st_d = RxIdle;
        endcase
    end

    assign rx_byte = shreg_q;

    always_comb begin
        ld_st_d  = ld_st_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        lane_d   = lane_q;
        word_d   = word_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        done_d   = done_q;
        err_d    = err_q;
        len_new  = {rx_byte, len_q[7:0]};
        wcnt_inc = wcnt_q + 17'd1;
        unique case (ld_st_q)
            LdLen0: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_byte;
                    ld_st_d    = LdLen1;
                end else if (rx_ferr) begin
                    ld_st_d = LdErr;
                    err_d   = 1'b1;
                end
            end
            LdLen1: begin
                if (rx_valid) begin
                    len_d = len_new;
                    if (len_new == 16'd0) begin
                        ld_st_d = LdDone;
                        done_d  = 1'b1;
                    end else if ({1'b0, len_new} > MaxWords) begin
                        ld_st_d = LdErr;
                        err_d   = 1'b1;
                    end else begin
                        ld_st_d = LdData;
                        wcnt_d  = 17'd0;
                        lane_d  = 2'd0;
                    end
                end else if (rx_ferr) begin
                    ld_st_d = LdErr;
                    err_d   = 1'b1;
                end
            end
            LdData: begin
                // Address advances as the write pulse ends; done follows the last write.
                if (we_q) begin
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc == {1'b0, len_q}) begin
                        ld_st_d = LdDone;
                        done_d  = 1'b1;
                    end
                end
                if (rx_valid) begin
                    word_d[{lane_q, 3'b000} +: 8] = rx_byte;
                    lane_d = lane_q + 1'b1;
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {rx_byte, word_q[23:0]};
                    end
                end else if (rx_ferr) begin
                    ld_st_d = LdErr;
                    err_d   = 1'b1;
                end
            end
            LdDone, LdErr: ;
            default: ld_st_d = LdErr;
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            rx_st_q   <= RxIdle;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shreg_q   <= 8'd0;
            ld_st_q   <= LdLen0;
            len_q     <= 16'd0;
            wcnt_q    <= 17'd0;
            lane_q    <= 2'd0;
            word_q    <= 32'd0;
            we_q      <= 1'b0;
            wdata_q   <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_meta_q <= w_rxd;
            rxs_q     <= rx_meta_q;
            rx_st_q   <= rx_st_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            ld_st_q   <= ld_st_d;
            len_q     <= len_d;
            wcnt_q    <= wcnt_d;
            lane_q    <= lane_d;
            word_q    <= word_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign w_we    = we_q;
    assign w_addr  = wcnt_q[ADDR_W-1:0];
    assign w_wdata = wdata_q;
    assign w_done  = done_q;
    assign w_err   = err_q;

endmodule
